load_store_unit: RTL and testbench

- Data-side stage directly downstream of the RV32I execute path: takes the ALU result as the effective address and the rs2 value as store data.
- Runs one load or store per request over a valid/ready memory port.
- Stalls the core via lsu_busy until the access completes.
- Returns sign/zero-extended load data for register writeback.

---
 rtl/load_store_unit.sv | 234 +++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I data-side load/store stage.
// Takes the ALU result as the effective address and rs2 as store data. It runs
// one access per request over a valid/ready memory port and returns
// sign/zero-extended load data.
// Ports:
//   clk, rst            - core clock (rising edge), async active-low reset
//   lsu_req/we/funct3   - core request; held high until lsu_done
//   lsu_addr/lsu_wdata  - effective byte address and store data
//   lsu_busy            - combinational stall (lsu_req & ~lsu_done)
//   lsu_done/err/rdata  - completion pulse, error flag, extended load data
//   mem_req_*           - request channel (valid/ready, addr, we, be, wdata)
//   mem_resp_*          - response/ack channel with load word
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_funct3,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata
);

  localparam int unsigned     CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e             state_q, state_d;
  logic               we_q, we_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [1:0]         off_q, off_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               valid_q, valid_d;
  logic [31:0]        addr_q, addr_d;
  logic               mem_we_q, mem_we_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        wdata_q, wdata_d;

  logic               req_legal_c, req_aligned_c;
  logic [3:0]         req_be_c;
  logic [31:0]        req_wdata_c;
  logic [31:0]        ld_shift_c, ld_data_c;

  assign lsu_busy      = lsu_req & ~done_q;
  assign lsu_done      = done_q;
  assign lsu_err       = err_q;
  assign lsu_rdata     = rdata_q;
  assign mem_req_valid = valid_q;
  assign mem_addr      = addr_q;
  assign mem_we        = mem_we_q;
  assign mem_be        = be_q;
  assign mem_wdata     = wdata_q;

  // Decode the incoming request: legality, alignment, byte lanes, replicated store data.
  always_comb begin
    req_aligned_c = 1'b0;
    req_be_c      = 4'b0000;
    req_wdata_c   = lsu_wdata;
    case (lsu_funct3[1:0])
      2'b00: begin
        req_aligned_c = 1'b1;
        req_be_c      = 4'b0001 << lsu_addr[1:0];
        req_wdata_c   = {4{lsu_wdata[7:0]}};
      end
      2'b01: begin
        req_aligned_c = ~lsu_addr[0];
        req_be_c      = 4'b0011 << {lsu_addr[1], 1'b0};
        req_wdata_c   = {2{lsu_wdata[15:0]}};
      end
      2'b10: begin
        req_aligned_c = (lsu_addr[1:0] == 2'b00);
        req_be_c      = 4'b1111;
      end
      default: ;
    endcase
    // Stores only have B/H/W; loads add BU/HU.
    if (lsu_we) begin
      req_legal_c = ~lsu_funct3[2] & (lsu_funct3[1:0] != 2'b11);
    end else begin
      req_legal_c = (lsu_funct3[1:0] != 2'b11) & ~(lsu_funct3[2] & lsu_funct3[1]);
    end
  end

  // Move the addressed lane down to bit 0, then extend according to the latched funct3.
  assign ld_shift_c = mem_resp_rdata >> {off_q, 3'b000};

  always_comb begin
    ld_data_c = ld_shift_c;
    case (funct3_q)
      F3_B:    ld_data_c = {{24{ld_shift_c[7]}}, ld_shift_c[7:0]};
      F3_H:    ld_data_c = {{16{ld_shift_c[15]}}, ld_shift_c[15:0]};
      F3_W:    ld_data_c = ld_shift_c;
      F3_BU:   ld_data_c = {24'h000000, ld_shift_c[7:0]};
      F3_HU:   ld_data_c = {16'h0000, ld_shift_c[15:0]};
      default: ld_data_c = ld_shift_c;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    valid_d  = 1'b0;
    addr_d   = addr_q;
    mem_we_d = mem_we_q;
    be_d     = be_q;
    wdata_d  = wdata_q;

    case (state_q)
      IDLE: begin
        if (lsu_req) begin
          we_d     = lsu_we;
          funct3_d = lsu_funct3;
          off_d    = lsu_addr[1:0];
          addr_d   = {lsu_addr[31:2], 2'b00};
          mem_we_d = lsu_we;
          be_d     = req_be_c;
          wdata_d  = req_wdata_c;
          if (req_legal_c && req_aligned_c) begin
            state_d = REQ;
            valid_d = 1'b1;
            cnt_d   = '0;
          end else begin
            // Rejected before any memory traffic.
            state_d = RESP;
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      REQ: begin
        // The budget is spent on this cycle: abandon even if ready arrives now.
        if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          done_d  = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (mem_req_ready) begin
            state_d = WAIT;
          end else begin
            valid_d = 1'b1;
          end
        end
      end
      WAIT: begin
        // A response on the last budget cycle still completes the access.
        if (mem_resp_valid) begin
          state_d = RESP;
          done_d  = 1'b1;
          rdata_d = we_q ? 32'h0 : ld_data_c;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          done_d  = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      valid_q  <= 1'b0;
      addr_q   <= '0;
      mem_we_q <= 1'b0;
      be_q     <= 4'b0000;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      mem_we_q <= mem_we_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: self-checking bench for load_store_unit (TIMEOUT = 8).
// Runs a table of hand-computed vectors, a timeout followed by a stray response,
// randomized accesses predicted by a transaction-level model, and a reset that
// lands mid-access.
module tb_load_store_unit;

  localparam int unsigned TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_req, lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_busy, lsu_done, lsu_err;
  logic [31:0] lsu_rdata;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_funct3(lsu_funct3),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_busy(lsu_busy), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  always #5 clk = ~clk;

  // One access: inputs, memory behaviour (ready delay dr, response delay dw), expectations.
  // exp_lat counts rising edges from the edge that samples lsu_req to lsu_done visible.
  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rword;
    int          dr;
    int          dw;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t row(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rword,
                               input int dr, input int dw, input logic err, input int lat,
                               input logic [31:0] rdata, input logic [3:0] be,
                               input logic [31:0] wd);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rword = rword;
    v.dr = dr; v.dw = dw; v.exp_err = err; v.exp_lat = lat; v.exp_rdata = rdata;
    v.exp_be = be; v.exp_wdata = wd;
    return v;
  endfunction

  // Transaction-level reference: sizes in bytes, arithmetic lane selection, and a
  // budget of TIMEOUT cycles shared by the request and response phases.
  function automatic vec_t model(input vec_t v);
    vec_t        r;
    int          size, off, need;
    bit          legal;
    logic [31:0] mask, sh, val, bei;
    r    = v;
    off  = int'(v.addr % 32'd4);
    case (int'(v.f3 % 3'd4))
      0:       size = 1;
      1:       size = 2;
      2:       size = 4;
      default: size = 0;
    endcase
    if (v.we) legal = (v.f3 <= 3'd2);
    else      legal = (v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    bei         = ((32'd1 << size) - 32'd1) << off;
    r.exp_be    = bei[3:0];
    case (size)
      1:       r.exp_wdata = (v.wdata & 32'hFF) * 32'h0101_0101;
      2:       r.exp_wdata = (v.wdata & 32'hFFFF) * 32'h0001_0001;
      default: r.exp_wdata = v.wdata;
    endcase
    sh   = v.rword >> (8 * off);
    mask = (size >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    val  = sh & mask;
    if (!v.f3[2] && size > 0 && size < 4 && sh[8 * size - 1]) val = val | ~mask;
    need = v.dr + 1 + v.dw + 1;
    if (!legal || size == 0 || (off % size) != 0) begin
      r.exp_err = 1'b1; r.exp_lat = 1; r.exp_rdata = 32'h0;
    end else if (need > int'(TIMEOUT)) begin
      r.exp_err = 1'b1; r.exp_lat = 1 + int'(TIMEOUT); r.exp_rdata = 32'h0;
    end else begin
      r.exp_err = 1'b0; r.exp_lat = 1 + need; r.exp_rdata = v.we ? 32'h0 : val;
    end
    return r;
  endfunction

  // Drive one request, act as the memory, and check the whole access.
  task automatic run_op(input vec_t v, input string tag);
    int          cyc = 0, req_cnt = 0, wait_cnt = 0;
    bit          accepted = 0, hs_pending = 0, saw_valid = 0, got_done = 0;
    bit          stable = 1, busy_ok = 1, valid_in_wait = 0;
    logic [31:0] a0, w0;
    logic [3:0]  b0;
    logic        we0;
    logic [31:0] exp_maddr;
    exp_maddr      = v.addr & 32'hFFFF_FFFC;
    a0 = '0; w0 = '0; b0 = '0; we0 = 1'b0;
    lsu_req        = 1'b1;
    lsu_we         = v.we;
    lsu_funct3     = v.f3;
    lsu_addr       = v.addr;
    lsu_wdata      = v.wdata;
    mem_resp_rdata = v.rword;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (lsu_done) begin
        got_done = 1;
        break;
      end
      if (lsu_busy !== 1'b1) busy_ok = 0;
      if (!accepted && hs_pending) begin
        accepted      = 1;
        mem_req_ready = 1'b0;
      end
      if (!accepted) begin
        if (mem_req_valid) begin
          if (!saw_valid) begin
            saw_valid = 1;
            a0 = mem_addr; b0 = mem_be; we0 = mem_we; w0 = mem_wdata;
            check({tag, ".mem_addr"}, mem_addr, exp_maddr);
            check({tag, ".mem_be"}, 32'(mem_be), 32'(v.exp_be));
            check({tag, ".mem_we"}, 32'(mem_we), 32'(v.we));
            if (v.we) check({tag, ".mem_wdata"}, mem_wdata, v.exp_wdata);
          end else if (mem_addr !== a0 || mem_be !== b0 || mem_we !== we0 || mem_wdata !== w0) begin
            stable = 0;
          end
          mem_req_ready = (req_cnt == v.dr);
          hs_pending    = mem_req_ready;
          req_cnt++;
        end
      end else begin
        if (mem_req_valid) valid_in_wait = 1;
        mem_resp_valid = (wait_cnt == v.dw);
        wait_cnt++;
      end
    end
    if (!got_done) begin
      check({tag, ".done_seen"}, 32'(got_done), 32'd1);
    end else begin
      check({tag, ".latency"}, cyc, v.exp_lat);
      check({tag, ".err"}, 32'(lsu_err), 32'(v.exp_err));
      check({tag, ".rdata"}, lsu_rdata, v.exp_rdata);
      check({tag, ".busy_at_done"}, 32'(lsu_busy), 32'd0);
    end
    check({tag, ".req_issued"}, 32'(saw_valid), 32'(v.exp_lat > 1));
    if (saw_valid) begin
      check({tag, ".payload_stable"}, 32'(stable), 32'd1);
      check({tag, ".valid_dropped"}, 32'(valid_in_wait), 32'd0);
    end
    if (cyc > 1) check({tag, ".busy"}, 32'(busy_ok), 32'd1);
    lsu_req        = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(lsu_done), 32'd0);
    if (got_done) check({tag, ".rdata_hold"}, lsu_rdata, v.exp_rdata);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[$];
    vec_t        v;
    logic [2:0]  ld_ok[5];
    bit          stray_done;
    ld_ok = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    rst = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0; lsu_funct3 = 3'd0;
    lsu_addr = '0; lsu_wdata = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    repeat (3) @(negedge clk);
    check("reset.done", 32'(lsu_done), 32'd0);
    check("reset.err", 32'(lsu_err), 32'd0);
    check("reset.rdata", lsu_rdata, 32'd0);
    check("reset.valid", 32'(mem_req_valid), 32'd0);
    check("reset.mem_we", 32'(mem_we), 32'd0);
    check("reset.mem_be", 32'(mem_be), 32'd0);
    check("reset.mem_addr", mem_addr, 32'd0);
    check("reset.mem_wdata", mem_wdata, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Hand-computed vectors: we, f3, addr, wdata, rword, dr, dw | err, lat, rdata, be, wdata.
    tbl.push_back(row(1'b0, 3'b000, 32'h1003, 32'h0, 32'h80FF_1234, 0, 0, 1'b0, 3, 32'hFFFF_FF80, 4'b1000, 32'h0));
    tbl.push_back(row(1'b1, 3'b001, 32'h2002, 32'h0000_ABCD, 32'h0, 4, 1, 1'b0, 8, 32'h0, 4'b1100, 32'hABCD_ABCD));
    tbl.push_back(row(1'b0, 3'b010, 32'h0006, 32'h0, 32'h0, 0, 0, 1'b1, 1, 32'h0, 4'b0000, 32'h0));
    tbl.push_back(row(1'b0, 3'b101, 32'h0002, 32'h0, 32'h8001_0000, 0, 0, 1'b0, 3, 32'h0000_8001, 4'b1100, 32'h0));
    tbl.push_back(row(1'b0, 3'b001, 32'h0002, 32'h0, 32'h8001_0000, 0, 0, 1'b0, 3, 32'hFFFF_8001, 4'b1100, 32'h0));
    tbl.push_back(row(1'b1, 3'b000, 32'h0101, 32'h1234_5678, 32'h0, 1, 0, 1'b0, 4, 32'h0, 4'b0010, 32'h7878_7878));
    tbl.push_back(row(1'b0, 3'b100, 32'h0002, 32'h0, 32'h11AA_2233, 0, 2, 1'b0, 5, 32'h0000_00AA, 4'b0100, 32'h0));
    tbl.push_back(row(1'b0, 3'b011, 32'h0000, 32'h0, 32'h0, 0, 0, 1'b1, 1, 32'h0, 4'b0000, 32'h0));
    tbl.push_back(row(1'b1, 3'b100, 32'h0000, 32'h0, 32'h0, 0, 0, 1'b1, 1, 32'h0, 4'b0000, 32'h0));
    tbl.push_back(row(1'b1, 3'b010, 32'h0102, 32'h1, 32'h0, 0, 0, 1'b1, 1, 32'h0, 4'b0000, 32'h0));
    tbl.push_back(row(1'b0, 3'b010, 32'h000C, 32'h0, 32'hDEAD_BEEF, 3, 3, 1'b0, 9, 32'hDEAD_BEEF, 4'b1111, 32'h0));
    tbl.push_back(row(1'b0, 3'b010, 32'h0008, 32'h0, 32'h1, 2, 10, 1'b1, 9, 32'h0, 4'b1111, 32'h0));
    tbl.push_back(row(1'b1, 3'b010, 32'h0010, 32'hA5A5_0F0F, 32'h0, 0, 0, 1'b0, 3, 32'h0, 4'b1111, 32'hA5A5_0F0F));
    tbl.push_back(row(1'b1, 3'b001, 32'h0000, 32'h1234_BEEF, 32'h0, 0, 0, 1'b0, 3, 32'h0, 4'b0011, 32'hBEEF_BEEF));
    foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i));

    // Ready never comes: abandoned after TIMEOUT cycles in REQ, then a late ack is ignored.
    run_op(row(1'b0, 3'b010, 32'h0040, 32'h0, 32'h0, 20, 0, 1'b1, 9, 32'h0, 4'b1111, 32'h0), "timeout");
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h7777_7777;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    stray_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (lsu_done) stray_done = 1;
    end
    check("stray_resp.no_done", 32'(stray_done), 32'd0);
    check("stray_resp.rdata", lsu_rdata, 32'd0);

    // Randomized accesses against the reference model.
    for (int n = 0; n < 80; n++) begin
      v.we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        if (v.we) v.f3 = 3'($urandom_range(0, 2));
        else      v.f3 = ld_ok[$urandom_range(0, 4)];
      end else begin
        v.f3 = 3'($urandom_range(0, 7));
      end
      v.addr = $urandom;
      if ($urandom_range(0, 1) != 0) begin
        if (v.f3[1:0] == 2'b01) v.addr[0] = 1'b0;
        if (v.f3[1:0] == 2'b10) v.addr[1:0] = 2'b00;
      end
      v.wdata = $urandom;
      v.rword = $urandom;
      v.dr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 2));
      v.dw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 2));
      v = model(v);
      run_op(v, $sformatf("rnd%0d", n));
    end

    // Reset landing in WAIT clears everything and no stale response is consumed.
    run_op(row(1'b0, 3'b010, 32'h0014, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b0, 3, 32'hCAFE_F00D, 4'b1111, 32'h0), "pre_rst");
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010;
    lsu_addr = 32'h0000_0020; lsu_wdata = 32'h5555_5555; mem_resp_rdata = 32'h1234_5678;
    @(negedge clk);
    check("rst_seq.valid", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("rst_seq.in_wait", 32'(mem_req_valid), 32'd0);
    lsu_req = 1'b0;
    rst     = 1'b0;
    #1;
    check("rst_mid.done", 32'(lsu_done), 32'd0);
    check("rst_mid.err", 32'(lsu_err), 32'd0);
    check("rst_mid.rdata", lsu_rdata, 32'd0);
    check("rst_mid.valid", 32'(mem_req_valid), 32'd0);
    check("rst_mid.mem_we", 32'(mem_we), 32'd0);
    check("rst_mid.mem_be", 32'(mem_be), 32'd0);
    check("rst_mid.mem_addr", mem_addr, 32'd0);
    check("rst_mid.mem_wdata", mem_wdata, 32'd0);
    check("rst_mid.busy", 32'(lsu_busy), 32'd0);
    @(negedge clk);
    rst            = 1'b1;
    mem_resp_valid = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    check("rst_mid.no_stale_done", 32'(lsu_done), 32'd0);
    run_op(row(1'b0, 3'b010, 32'h0010, 32'h0, 32'h0BAD_F00D, 1, 1, 1'b0, 5, 32'h0BAD_F00D, 4'b1111, 32'h0), "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
